// File: rtl/spice_node_integrator_pkg.sv
// Node-wide constants shared by every integrator instance: voltage width, rails,
// quiescence tolerance and the digital-level thresholds.
package spice_node_integrator_pkg;

  localparam int SPICE_W         = 11;
  localparam int SPICE_HI        = (1 << SPICE_W) - 1;
  localparam int SPICE_LO        = -(1 << SPICE_W);
  localparam int SPICE_EPS_DEF   = 1;
  localparam int SPICE_TH_HI_DEF = SPICE_HI / 4;
  localparam int SPICE_TH_LO_DEF = -(SPICE_HI / 4);

  // Width of a sum over n_in voltage-width currents that cannot overflow.
  function automatic int sum_width(input int n_in);
    return SPICE_W + 1 + $clog2(n_in);
  endfunction

endpackage

// File: rtl/spice_current_sum.sv
// Combinational reduction of N_IN packed signed device currents into one widened sum.
module spice_current_sum
  import spice_node_integrator_pkg::*;
#(
  parameter int N_IN = 8
) (
  input  logic [N_IN*(SPICE_W+1)-1:0] i_in,
  output logic [sum_width(N_IN)-1:0]  sum
);

  localparam int VW = SPICE_W + 1;
  localparam int SW = sum_width(N_IN);

  logic [N_IN-1:0][SW-1:0] lane;
  logic [SW-1:0]           acc;

  genvar k;
  generate
    for (k = 0; k < N_IN; k++) begin : g_lane
      logic signed [VW-1:0] slot;
      assign slot    = signed'(i_in[k*VW +: VW]);
      assign lane[k] = SW'(slot);
    end
  endgenerate

  // Two's-complement wraparound is harmless: SW bits always hold the true sum.
  always_comb begin
    acc = '0;
    for (int j = 0; j < N_IN; j++) acc = acc + lane[j];
  end

  assign sum = acc;

endmodule

// File: rtl/spice_node_integrator.sv
// Per-node integrator: accumulates summed device current into a clamped node voltage
// each step, with hysteretic digital level, saturation and settle tracking.
module spice_node_integrator
  import spice_node_integrator_pkg::*;
#(
  parameter int N_IN      = 8,
  parameter int CAP_SHIFT = 2,
  parameter int EPS       = SPICE_EPS_DEF,
  parameter int SETTLE_N  = 4,
  parameter int TH_HI     = SPICE_TH_HI_DEF,
  parameter int TH_LO     = SPICE_TH_LO_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step,
  input  logic                       force_en,
  input  logic [SPICE_W:0]           force_v,
  input  logic [N_IN*(SPICE_W+1)-1:0] i_in,
  output logic [SPICE_W:0]           v,
  output logic                       p,
  output logic                       settled,
  output logic                       sat
);

  localparam int VW = SPICE_W + 1;
  localparam int SW = sum_width(N_IN);
  localparam int EW = SW + 1;

  localparam logic signed [EW-1:0] HI_E  = EW'(SPICE_HI);
  localparam logic signed [EW-1:0] LO_E  = EW'(SPICE_LO);
  localparam logic signed [SW-1:0] EPS_P = SW'(EPS);
  localparam logic signed [SW-1:0] EPS_N = SW'(-EPS);
  localparam logic signed [VW-1:0] TH_HI_V = VW'(TH_HI);
  localparam logic signed [VW-1:0] TH_LO_V = VW'(TH_LO);
  localparam logic [3:0]           SN    = 4'(SETTLE_N);

  logic [SW-1:0]        sum_raw;
  logic signed [SW-1:0] sum_s, dv;
  logic signed [VW-1:0] v_s, v_clamp, v_upd;
  logic signed [EW-1:0] vn;
  logic                 hi_clip, lo_clip, quiet, p_new;
  logic [3:0]           cnt, cnt_new;

  spice_current_sum #(.N_IN(N_IN)) u_sum (
    .i_in (i_in),
    .sum  (sum_raw)
  );

  assign sum_s   = signed'(sum_raw);
  assign dv      = sum_s >>> CAP_SHIFT;
  assign v_s     = signed'(v);
  assign vn      = EW'(v_s) + EW'(dv);
  assign hi_clip = vn > HI_E;
  assign lo_clip = vn < LO_E;

  // v starts inside the rails, so any clip means dv is pushing into that rail.
  always_comb begin
    v_clamp = vn[VW-1:0];
    if (hi_clip)      v_clamp = VW'(SPICE_HI);
    else if (lo_clip) v_clamp = VW'(SPICE_LO);
    quiet   = ((dv <= EPS_P) && (dv >= EPS_N)) || hi_clip || lo_clip;
    cnt_new = '0;
    if (quiet) cnt_new = (cnt == SN) ? cnt : cnt + 4'd1;
    v_upd = force_en ? signed'(force_v) : v_clamp;
    // Hysteresis tracks whatever voltage the node takes, forced or integrated.
    p_new = p;
    if (v_upd >= TH_HI_V)      p_new = 1'b1;
    else if (v_upd <= TH_LO_V) p_new = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v       <= VW'(SPICE_LO);
      p       <= 1'b0;
      settled <= 1'b0;
      sat     <= 1'b0;
      cnt     <= '0;
    end else if (step) begin
      v <= v_upd;
      p <= p_new;
      if (force_en) begin
        sat     <= 1'b0;
        cnt     <= '0;
        settled <= 1'b0;
      end else begin
        sat     <= hi_clip | lo_clip;
        cnt     <= cnt_new;
        settled <= (cnt_new == SN);
      end
    end
  end

endmodule

// File: tb/tb_spice_node_integrator.sv
// Self-checking bench: directed scenarios with literal expectations plus a random run,
// all compared every cycle against a behavioural node model.
module tb_spice_node_integrator;
  import spice_node_integrator_pkg::*;

  localparam int N_IN = 8;
  localparam int CAP_SHIFT = 2;
  localparam int EPS = SPICE_EPS_DEF;
  localparam int SETTLE_N = 4;
  localparam int TH_HI = SPICE_TH_HI_DEF;
  localparam int TH_LO = SPICE_TH_LO_DEF;
  localparam int VW = SPICE_W + 1;

  logic clk = 1'b0;
  logic reset, step, force_en;
  logic [VW-1:0] force_v;
  logic [N_IN*VW-1:0] i_in;
  logic [VW-1:0] v;
  logic p, settled, sat;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_v, m_cnt;
  bit m_p, m_settled, m_sat;

  spice_node_integrator #(
    .N_IN(N_IN), .CAP_SHIFT(CAP_SHIFT), .EPS(EPS), .SETTLE_N(SETTLE_N),
    .TH_HI(TH_HI), .TH_LO(TH_LO)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .force_en(force_en), .force_v(force_v),
    .i_in(i_in), .v(v), .p(p), .settled(settled), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int s);
    int d, q;
    d = 1 << CAP_SHIFT;
    q = s / d;
    if (s < 0 && (s % d) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int vsig(input logic [VW-1:0] x);
    logic signed [VW-1:0] t;
    t = signed'(x);
    return int'(t);
  endfunction

  // Behavioural model: clamp(v + floor(sum / 2^CAP_SHIFT)) with settle and hysteresis rules.
  always @(posedge clk) begin
    int s, dv, vn;
    bit quiet;
    if (reset) begin
      m_v = SPICE_LO; m_p = 0; m_cnt = 0; m_settled = 0; m_sat = 0;
    end else if (step) begin
      if (force_en) begin
        m_v = vsig(force_v); m_sat = 0; m_cnt = 0; m_settled = 0;
      end else begin
        s = 0;
        for (int k = 0; k < N_IN; k++) s += vsig(i_in[k*VW +: VW]);
        dv = floor_div(s);
        vn = m_v + dv;
        m_sat = (vn > SPICE_HI) || (vn < SPICE_LO);
        m_v = (vn > SPICE_HI) ? SPICE_HI : (vn < SPICE_LO) ? SPICE_LO : vn;
        quiet = (dv <= EPS && dv >= -EPS) || m_sat;
        m_cnt = quiet ? ((m_cnt + 1 > SETTLE_N) ? SETTLE_N : m_cnt + 1) : 0;
        m_settled = (m_cnt == SETTLE_N);
      end
      if (m_v >= TH_HI) m_p = 1;
      else if (m_v <= TH_LO) m_p = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_v", vsig(v), m_v);
      chk("model_p", int'(p), int'(m_p));
      chk("model_settled", int'(settled), int'(m_settled));
      chk("model_sat", int'(sat), int'(m_sat));
    end
  end

  task automatic set_slots(input int a0, input int oth);
    for (int k = 0; k < N_IN; k++) i_in[k*VW +: VW] = (k == 0) ? a0[VW-1:0] : oth[VW-1:0];
  endtask

  task automatic do_force(input int fv);
    int t;
    t = fv;
    step = 1; force_en = 1; force_v = t[VW-1:0];
    @(negedge clk);
    force_en = 0;
  endtask

  task automatic steps(input int a0, input int n);
    step = 1; set_slots(a0, 0);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit rose;
    int r;
    reset = 1; step = 1; force_en = 0; force_v = '0;
    set_slots(100, 100);
    @(negedge clk);
    chk_en = 1;
    // 1: reset dominates step
    for (int c = 0; c < 3; c++) begin
      chk("rst_v", vsig(v), SPICE_LO);
      chk("rst_p", int'(p), 0);
      chk("rst_settled", int'(settled), 0);
      if (c < 2) @(negedge clk);
    end
    reset = 0;
    @(negedge clk);
    chk("first_step_v", vsig(v), -1848);

    // 2: ramp from 0 with slot0=+64
    do_force(0);
    steps(64, 1); chk("ramp_v1", vsig(v), 16);
    steps(64, 1); chk("ramp_v2", vsig(v), 32);
    steps(64, 1); chk("ramp_v3", vsig(v), 48);
    rose = 0;
    for (int i = 0; i < 40 && !rose; i++) begin
      @(negedge clk);
      if (p) rose = 1;
    end
    chk("ramp_p_rose", int'(rose), 1);
    chk("ramp_v_at_p", vsig(v), 512);

    // 3: clamp at rail counts as quiet
    do_force(SPICE_HI - 10);
    steps(1000, 1);
    chk("clamp_v", vsig(v), SPICE_HI);
    chk("clamp_sat", int'(sat), 1);
    steps(1000, 2); chk("clamp_settled3", int'(settled), 0);
    steps(1000, 1); chk("clamp_settled4", int'(settled), 1);

    // 5: settle, disturb, force
    do_force(0);
    steps(0, 4); chk("quiet_settled", int'(settled), 1);
    steps(1000, 1);
    chk("kick_v", vsig(v), 250);
    chk("kick_settled", int'(settled), 0);
    steps(0, 1); chk("restart_settled", int'(settled), 0);
    do_force(-5);
    chk("force_v", vsig(v), -5);
    chk("force_settled", int'(settled), 0);

    // 4: hysteresis sweep
    do_force(508);
    steps(16, 1); chk("hys_top_v", vsig(v), 512); chk("hys_top_p", int'(p), 1);
    steps(-584, 7); chk("hys_dn_v", vsig(v), TH_LO + 1); chk("hys_dn_p", int'(p), 1);
    steps(-4, 1); chk("hys_lo_v", vsig(v), TH_LO); chk("hys_lo_p", int'(p), 0);
    steps(584, 6); steps(580, 1);
    chk("hys_up_v", vsig(v), TH_HI - 1); chk("hys_up_p", int'(p), 0);

    // 6: no step means hold
    step = 0;
    for (int c = 0; c < 10; c++) begin
      set_slots($urandom_range(1, 2000), $urandom_range(1, 2000));
      force_en = c[0];
      @(negedge clk);
      chk("hold_v", vsig(v), TH_HI - 1);
      chk("hold_p", int'(p), 0);
      chk("hold_sat", int'(sat), 0);
      chk("hold_settled", int'(settled), 0);
    end
    force_en = 0;

    // random run against the model
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      reset = (r == 0);
      step = ($urandom_range(0, 3) != 0);
      force_en = ($urandom_range(0, 29) == 0);
      force_v = VW'($urandom);
      for (int k = 0; k < N_IN; k++) begin
        if ($urandom_range(0, 2) == 0) r = $urandom_range(0, 4) - 2;
        else r = int'($urandom_range(0, 4095)) - 2048;
        i_in[k*VW +: VW] = r[VW-1:0];
      end
      @(negedge clk);
    end
    reset = 0; step = 0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
